// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-channel round-robin select arbiter.
//   N_CH        : number of arbitrated channels
//   SEL_W       : width of the mux select / channel index
//   arb_state_t : arbiter FSM state
//   onehot4()   : channel index -> one-hot grant vector
package arb_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic logic [N_CH-1:0] onehot4(input logic [SEL_W-1:0] sel);
    onehot4 = N_CH'(1) << sel;
  endfunction

endpackage

// File: rtl/mux4to1.sv
// Downstream 4:1 data multiplexer steered by the arbiter select.
//   sel [1:0] : source select (0=a, 1=b, 2=c, 3=d)
//   a..d      : data sources
//   out       : selected source
module mux4to1 (
  input  logic [1:0] sel,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic       out
);

  always_comb begin
    out = a;
    case (sel)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority search: first eligible channel scanning ptr, ptr+1, ... (mod 4).
//   req  [3:0] : request vector
//   ptr  [1:0] : channel with highest priority
//   mask [3:0] : channels excluded from the search
//   any        : at least one eligible channel
//   idx  [1:0] : winning channel (ptr when nothing is eligible)
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_CH-1:0]  mask,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [N_CH-1:0]  elig;
  logic [SEL_W-1:0] cand;

  assign elig = req & ~mask;

  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = ptr + SEL_W'(k);
      if (!any && elig[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter4.sv
// Round-robin arbiter producing the select for a downstream mux4to1.
// Optional hold-limit timeout enabled by defining ARB_TIMEOUT_EN.
//   clk           : rising-edge clock
//   rst_n         : asynchronous active-low reset
//   req     [3:0] : per-channel request (bit i = mux input i)
//   done          : owner ends its transfer (1-cycle pulse)
//   sel     [1:0] : mux select = granted channel; held while idle
//   grant   [3:0] : one-hot grant, zero when idle
//   valid         : a channel owns the mux
//   timeout       : 1-cycle pulse after a hold-limit revocation
module rr_sel_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  grant,
  output logic             valid,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("rr_sel_arbiter4: MAX_HOLD must be in 2..256");
  end

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             release_c;
  logic             hold_hit_c;
  logic [SEL_W-1:0] pick_ptr_c;
  logic [N_CH-1:0]  pick_mask_c;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_keep_c;

  assign hold_hit_c  = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign hold_keep_c = (state_q == GRANT) && !release_c;

  // Counts cycles of the current ownership; cleared on every new grant.
  always_comb begin
    hold_cnt_d = '0;
    if (hold_keep_c) begin
      hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end
`else
  assign hold_hit_c = 1'b0;
`endif

  // sel_q doubles as the owner index while in GRANT.
  assign release_c = (state_q == GRANT) && (!req[sel_q] || done || hold_hit_c);

  // While granted, the search starts after the owner and excludes it.
  assign pick_ptr_c  = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;
  assign pick_mask_c = (state_q == GRANT) ? onehot4(sel_q) : '0;

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (pick_ptr_c),
    .mask (pick_mask_c),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          grant_d = onehot4(pick_idx);
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_d     = sel_q + SEL_W'(1);
          timeout_d = hold_hit_c && !done && req[sel_q];
          if (pick_any) begin
            sel_d   = pick_idx;
            grant_d = onehot4(pick_idx);
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Self-checking bench: rr_sel_arbiter4 steering mux4to1, scoreboard against a behavioural model.
module tb_rr_sel_arbiter4;

  localparam int unsigned MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic       timeout;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic       mux_out;

  always #5 clk = ~clk;

  rr_sel_arbiter4 #(.MAX_HOLD(MAX_HOLD)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  mux4to1 u_mux (
    .sel (sel),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .out (mux_out)
  );

  typedef struct {
    logic       valid;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       timeout;
    logic       mux;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  bit         m_gnt   = 1'b0;
  logic [1:0] m_owner = 2'd0;
  logic [1:0] m_ptr   = 2'd0;
  int         m_hold  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int pick(input logic [3:0] r, input logic [1:0] p);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (int'(p) + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_gnt   = 1'b0;
    m_owner = 2'd0;
    m_ptr   = 2'd0;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic dn, input logic [3:0] data,
                            output exp_t e);
    bit tmo;
    bit hit;
    bit rel;
    int w;
    tmo = 1'b0;
    if (!m_gnt) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_gnt   = 1'b1;
        m_owner = 2'(w);
        m_hold  = 0;
      end
    end else begin
      hit = TMO_EN && (m_hold == int'(MAX_HOLD) - 1);
      rel = !r[m_owner] || dn || hit;
      tmo = hit && !dn && r[m_owner];
      if (rel) begin
        m_ptr = m_owner + 2'd1;
        w = pick(r & ~(4'b0001 << m_owner), m_ptr);
        if (w >= 0) begin
          m_owner = 2'(w);
          m_hold  = 0;
        end else begin
          m_gnt = 1'b0;
        end
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end
    e.valid   = m_gnt;
    e.grant   = m_gnt ? (4'b0001 << m_owner) : 4'b0000;
    e.sel     = m_owner;
    e.timeout = tmo;
    e.mux     = data[m_owner];
  endtask

  // One clock of stimulus: drive at negedge, predict, compare just after the edge.
  task automatic drive(input logic [3:0] r, input logic dn, input logic [3:0] data);
    exp_t e;
    exp_t o;
    @(negedge clk);
    req  = r;
    done = dn;
    {d, c, b, a} = data;
    model_step(r, dn, data, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      o = exp_q.pop_front();
      check_eq("valid",   32'(valid),   32'(o.valid));
      check_eq("grant",   32'(grant),   32'(o.grant));
      check_eq("sel",     32'(sel),     32'(o.sel));
      check_eq("timeout", 32'(timeout), 32'(o.timeout));
      check_eq("mux_out", 32'(mux_out), 32'(o.mux));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_valid"},   32'(valid),   32'd0);
    check_eq({tag, "_grant"},   32'(grant),   32'd0);
    check_eq({tag, "_sel"},     32'(sel),     32'd0);
    check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = 4'b0000;
    done  = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    // Reset then idle
    #12;
    check_zero_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(4'b0000, 1'b0, 4'b0101);

    // Single requester on channel 2, a=1 b=0 c=1 d=0
    drive(4'b0100, 1'b0, 4'b0101);
    check_eq("single_grant", 32'(grant), 32'h4);
    drive(4'b0100, 1'b0, 4'b0101);
    drive(4'b0100, 1'b1, 4'b0101);
    check_eq("single_idle_sel", 32'(sel), 32'd2);
    drive(4'b0000, 1'b0, 4'b0101);

    // Round robin with all requesting, done every 3rd cycle
    do_reset();
    for (int i = 0; i < 14; i++) drive(4'b1111, (i % 3 == 2), 4'b1010);

    // Wrap and mask
    do_reset();
    drive(4'b1000, 1'b0, 4'b0110);
    drive(4'b1001, 1'b1, 4'b0110);
    check_eq("wrap_grant", 32'(grant), 32'h1);
    drive(4'b1000, 1'b0, 4'b0110);
    drive(4'b1000, 1'b1, 4'b0110);
    check_eq("mask_idle_valid", 32'(valid), 32'd0);
    drive(4'b1000, 1'b0, 4'b0110);
    check_eq("mask_regrant", 32'(grant), 32'h8);
    drive(4'b0000, 1'b0, 4'b0110);

    // Hold limit: two requesters, no done
    do_reset();
    for (int i = 0; i < 24; i++) drive(4'b0011, 1'b0, 4'b0001);

    // Asynchronous reset mid-grant
    do_reset();
    drive(4'b0100, 1'b0, 4'b1111);
    drive(4'b0100, 1'b0, 4'b1111);
    @(posedge clk);
    #2;
    req   = 4'b0000;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 1'b0, 4'b1111);
    check_eq("post_rst_grant", 32'(grant), 32'h1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 120; i++) begin
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
